pwm_channel_scheduler: RTL and testbench
========================================

Name: pwm_channel_scheduler

Overview:
Time-multiplexes one pulse-width measurement timer across NUM_CHANNELS RC servo PWM inputs. It scans the channels round-robin, measures one complete high pulse per channel, and classifies it against hysteresis thresholds. It holds one registered state bit and one valid bit per channel. It replaces per-channel analyzers and feeds the ones counter / 7-segment path with the same state vector. Design clock is 1 MHz, so 1 count = 1 us.

Parameters:
NUM_CHANNELS, 8, number of PWM inputs scanned (>=2)
MAX_COUNTER_VALUE, 2000, longest legal pulse in clocks; reaching it while high = overrange
HIGH_COUNTER_VALUE, 1800, width > this -> state 1
LOW_COUNTER_VALUE, 1200, width < this -> state 0
TIMEOUT_VALUE, 25000, max clocks spent waiting for low-level or rising edge on a channel

Ports:
clock_i  in  1  single design clock, rising edge
reset_n_i  in  1  asynchronous, active-low reset
enable_i  in  1  scan enable; low stops scanning
pwm_i  in  NUM_CHANNELS  raw asynchronous PWM inputs
channel_state_o  out  NUM_CHANNELS  classified state per channel
channel_valid_o  out  NUM_CHANNELS  1 = last measurement legal
active_channel_o  out  $clog2(NUM_CHANNELS)  channel currently owning the timer
pulse_width_o  out  $clog2(MAX_COUNTER_VALUE+1)  width of last completed measurement
result_strobe_o  out  1  one-cycle pulse when outputs updated

Behaviour:
- Reset (async assert, sync release): FSM=IDLE, channel=0, timer=0, all outputs 0.
- Inputs pass through a 2-flop synchronizer, sel = sync[channel]. The FSM sees only sel.
- Timer: one shared counter, width $clog2(TIMEOUT_VALUE+1). Cleared on every state entry except MEASURE (set to 1).
- IDLE: enable_i=1 -> SYNC_LOW.
- SYNC_LOW: waits for sel=0 so measurement never starts mid-pulse. sel=0 -> WAIT_RISE. Timer reaches TIMEOUT_VALUE -> UPDATE(timeout).
- WAIT_RISE: sel=1 -> MEASURE, timer=1. Timer reaches TIMEOUT_VALUE -> UPDATE(timeout).
- MEASURE: sel=1 -> timer+1. sel=0 -> UPDATE(ok, width=timer). Timer reaches MAX_COUNTER_VALUE with sel=1 -> UPDATE(overrange).
  - Width = number of synchronized high cycles. A clean pulse of H clocks yields exactly H.
- UPDATE (one cycle; outputs registered at its end, strobe high in the following cycle):
  - ok: valid=1, pulse_width_o=width. State=1 if width>HIGH, 0 if width<LOW, else hold previous (hysteresis; equality holds).
  - overrange: valid=0, state=0 (failsafe), pulse_width_o=MAX_COUNTER_VALUE.
  - timeout: valid=0, state=0, pulse_width_o=0.
  - Only the bit of the current channel changes. Channel advances: N-1 wraps to 0.
  - Next state: enable_i=1 -> SYNC_LOW, else IDLE.
- Latency: input falling edge sampled at edge k -> result_strobe_o, outputs valid from edge k+4.
- enable_i=0 in SYNC_LOW/WAIT_RISE/MEASURE: abort to IDLE next cycle. No update, no strobe, channel unchanged, outputs hold. Re-enable restarts the same channel from SYNC_LOW.
- enable_i=0 during UPDATE: the update completes, then IDLE.
- Reset mid-measurement: immediate return to reset values.
- Timer never wraps; the limit compare takes priority over the sel transition in the same cycle.
- active_channel_o = channel register. It changes only on UPDATE.

Decomposition:
- Shared package: FSM state encoding (IDLE, SYNC_LOW, WAIT_RISE, MEASURE, UPDATE), result codes (OK, OVERRANGE, TIMEOUT), width helper constants.
- One sub-module: pwm_input_sync (parameterized-width 2-flop synchronizer, async active-low reset to 0).
- Classification stays inline.

Test Plan:
Bench parameters: N=4, MAX=20, HIGH=15, LOW=10, TIMEOUT=50.
- Reset: hold reset_n_i=0, toggle pwm_i -> all outputs 0, active_channel_o=0. Release with enable=1 -> SYNC_LOW.
- Classify: ch0 pulse 17 clocks -> pulse_width_o=17, state[0]=1, valid[0]=1, strobe one cycle at edge k+4, active_channel_o->1. Ch1 pulse 8 -> state[1]=0.
- Hysteresis: ch2 set to 1 by width 17, next visit width 12, then 15 -> state[2] stays 1 both times. Width 9 -> state[2]=0.
- Overrange/timeout: ch3 held high 30 clocks -> width 20, valid[3]=0, state[3]=0. Ch0 held low forever -> after 50 clocks in WAIT_RISE, width 0, valid[0]=0, channel advances.
- Wrap/round-robin: all four channels pulse 17 -> four strobes in order 0,1,2,3, then active_channel_o=0 again.
- Abort: drop enable_i mid-MEASURE on ch2 -> no strobe, outputs unchanged, active_channel_o=2. Re-enable -> ch2 re-measured from SYNC_LOW.

Source files
------------

// File: rtl/pwm_channel_scheduler_pkg.sv
// Shared types for the PWM channel scheduler: FSM states, measurement result
// codes and a counter width helper.
package pwm_channel_scheduler_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SYNC_LOW,
        ST_WAIT_RISE,
        ST_MEASURE,
        ST_UPDATE
    } state_e;

    typedef enum logic [1:0] {
        RES_OK,
        RES_OVERRANGE,
        RES_TIMEOUT
    } result_e;

    function automatic int unsigned count_width(input int unsigned max_value);
        return (max_value < 1) ? 1 : $clog2(max_value + 1);
    endfunction

endpackage

// File: rtl/pwm_input_sync.sv
// Parameterized-width two-flop synchronizer for asynchronous PWM inputs.
module pwm_input_sync #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clock_i,
    input  logic             reset_n_i,
    input  logic [WIDTH-1:0] async_i,
    output logic [WIDTH-1:0] sync_o
);

    logic [WIDTH-1:0] meta_q;
    logic [WIDTH-1:0] sync_q;

    always_ff @(posedge clock_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            meta_q <= '0;
            sync_q <= '0;
        end else begin
            meta_q <= async_i;
            sync_q <= meta_q;
        end
    end

    assign sync_o = sync_q;

endmodule

// File: rtl/pwm_channel_scheduler.sv
// Round-robin pulse-width measurement of NUM_CHANNELS PWM inputs with one
// shared timer and hysteresis classification into a per-channel state bit.
module pwm_channel_scheduler
    import pwm_channel_scheduler_pkg::*;
#(
    parameter int unsigned NUM_CHANNELS      = 8,
    parameter int unsigned MAX_COUNTER_VALUE = 2000,
    parameter int unsigned HIGH_COUNTER_VALUE = 1800,
    parameter int unsigned LOW_COUNTER_VALUE = 1200,
    parameter int unsigned TIMEOUT_VALUE     = 25000
) (
    input  logic                                   clock_i,
    input  logic                                   reset_n_i,
    input  logic                                   enable_i,
    input  logic [NUM_CHANNELS-1:0]                pwm_i,
    output logic [NUM_CHANNELS-1:0]                channel_state_o,
    output logic [NUM_CHANNELS-1:0]                channel_valid_o,
    output logic [$clog2(NUM_CHANNELS)-1:0]        active_channel_o,
    output logic [$clog2(MAX_COUNTER_VALUE+1)-1:0] pulse_width_o,
    output logic                                   result_strobe_o
);

    localparam int unsigned CW = $clog2(NUM_CHANNELS);
    localparam int unsigned PW = count_width(MAX_COUNTER_VALUE);
    localparam int unsigned TW = count_width(TIMEOUT_VALUE);

    state_e                  state_q,  state_d;
    result_e                 result_q, result_d;
    logic [CW-1:0]           chan_q,   chan_d;
    logic [TW-1:0]           timer_q,  timer_d;
    logic [PW-1:0]           meas_q,   meas_d;
    logic [PW-1:0]           width_q,  width_d;
    logic [NUM_CHANNELS-1:0] bits_q,   bits_d;
    logic [NUM_CHANNELS-1:0] valid_q,  valid_d;
    logic                    strobe_q, strobe_d;
    logic [NUM_CHANNELS-1:0] sync_w;
    logic                    sel_q;
    logic                    at_timeout;
    logic                    at_max;

    pwm_input_sync #(
        .WIDTH (NUM_CHANNELS)
    ) u_sync (
        .clock_i   (clock_i),
        .reset_n_i (reset_n_i),
        .async_i   (pwm_i),
        .sync_o    (sync_w)
    );

    assign at_timeout = (timer_q == TW'(TIMEOUT_VALUE));
    assign at_max     = (timer_q >= TW'(MAX_COUNTER_VALUE));

    always_ff @(posedge clock_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q  <= ST_IDLE;
            result_q <= RES_OK;
            chan_q   <= '0;
            timer_q  <= '0;
            meas_q   <= '0;
            width_q  <= '0;
            bits_q   <= '0;
            valid_q  <= '0;
            strobe_q <= 1'b0;
            sel_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            result_q <= result_d;
            chan_q   <= chan_d;
            timer_q  <= timer_d;
            meas_q   <= meas_d;
            width_q  <= width_d;
            bits_q   <= bits_d;
            valid_q  <= valid_d;
            strobe_q <= strobe_d;
            // Select by the next channel so sel never carries a stale bit across a switch
            sel_q    <= sync_w[chan_d];
        end
    end

    always_comb begin
        state_d  = state_q;
        result_d = result_q;
        chan_d   = chan_q;
        timer_d  = timer_q;
        meas_d   = meas_q;
        width_d  = width_q;
        bits_d   = bits_q;
        valid_d  = valid_q;
        strobe_d = 1'b0;

        case (state_q)
            ST_IDLE: begin
                timer_d = '0;
                if (enable_i) state_d = ST_SYNC_LOW;
            end
            ST_SYNC_LOW, ST_WAIT_RISE: begin
                if (!enable_i) begin
                    state_d = ST_IDLE;
                    timer_d = '0;
                end else if (at_timeout) begin
                    state_d  = ST_UPDATE;
                    result_d = RES_TIMEOUT;
                    timer_d  = '0;
                end else if (state_q == ST_SYNC_LOW && !sel_q) begin
                    state_d = ST_WAIT_RISE;
                    timer_d = '0;
                end else if (state_q == ST_WAIT_RISE && sel_q) begin
                    state_d = ST_MEASURE;
                    timer_d = TW'(1);
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end
            ST_MEASURE: begin
                if (!enable_i) begin
                    state_d = ST_IDLE;
                    timer_d = '0;
                end else if (at_max) begin
                    state_d  = ST_UPDATE;
                    result_d = RES_OVERRANGE;
                    timer_d  = '0;
                end else if (!sel_q) begin
                    state_d  = ST_UPDATE;
                    result_d = RES_OK;
                    meas_d   = timer_q[PW-1:0];
                    timer_d  = '0;
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end
            ST_UPDATE: begin
                strobe_d = 1'b1;
                timer_d  = '0;
                case (result_q)
                    RES_OK: begin
                        valid_d[chan_q] = 1'b1;
                        width_d         = meas_q;
                        if (meas_q > PW'(HIGH_COUNTER_VALUE))     bits_d[chan_q] = 1'b1;
                        else if (meas_q < PW'(LOW_COUNTER_VALUE)) bits_d[chan_q] = 1'b0;
                    end
                    RES_OVERRANGE: begin
                        valid_d[chan_q] = 1'b0;
                        bits_d[chan_q]  = 1'b0;
                        width_d         = PW'(MAX_COUNTER_VALUE);
                    end
                    default: begin
                        valid_d[chan_q] = 1'b0;
                        bits_d[chan_q]  = 1'b0;
                        width_d         = '0;
                    end
                endcase
                chan_d  = (chan_q == CW'(NUM_CHANNELS - 1)) ? '0 : chan_q + CW'(1);
                state_d = enable_i ? ST_SYNC_LOW : ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign channel_state_o  = bits_q;
    assign channel_valid_o  = valid_q;
    assign active_channel_o = chan_q;
    assign pulse_width_o    = width_q;
    assign result_strobe_o  = strobe_q;

endmodule

// File: tb/tb_pwm_channel_scheduler.sv
// Directed bench for pwm_channel_scheduler with a scoreboard of expected
// per-update results checked on every result strobe.
module tb_pwm_channel_scheduler;
    import pwm_channel_scheduler_pkg::*;

    localparam int N     = 4;
    localparam int MAXV  = 20;
    localparam int HIGHV = 15;
    localparam int LOWV  = 10;
    localparam int TOV   = 50;

    logic         clk   = 1'b0;
    logic         rst_n = 1'b0;
    logic         en    = 1'b0;
    logic [N-1:0] pwm   = '0;
    logic [N-1:0] st_o;
    logic [N-1:0] vl_o;
    logic [1:0]   act_o;
    logic [4:0]   pw_o;
    logic         strobe_o;

    pwm_channel_scheduler #(
        .NUM_CHANNELS       (N),
        .MAX_COUNTER_VALUE  (MAXV),
        .HIGH_COUNTER_VALUE (HIGHV),
        .LOW_COUNTER_VALUE  (LOWV),
        .TIMEOUT_VALUE      (TOV)
    ) dut (
        .clock_i          (clk),
        .reset_n_i        (rst_n),
        .enable_i         (en),
        .pwm_i            (pwm),
        .channel_state_o  (st_o),
        .channel_valid_o  (vl_o),
        .active_channel_o (act_o),
        .pulse_width_o    (pw_o),
        .result_strobe_o  (strobe_o)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int           ch;
        int           width;
        logic [N-1:0] st;
        logic [N-1:0] vl;
        int           due;
    } exp_t;

    exp_t         sb[$];
    logic [N-1:0] m_st = '0;
    logic [N-1:0] m_vl = '0;
    int           last_w = 0;
    int           tests = 0;
    int           fails = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // kind: 0 = ok, 1 = overrange, 2 = timeout
    task automatic push_exp(input int ch, input int w, input int kind, input int due);
        exp_t e;
        case (kind)
            0: begin
                m_vl[ch] = 1'b1;
                if (w > HIGHV)     m_st[ch] = 1'b1;
                else if (w < LOWV) m_st[ch] = 1'b0;
                last_w = w;
            end
            1: begin
                m_vl[ch] = 1'b0;
                m_st[ch] = 1'b0;
                last_w   = MAXV;
            end
            default: begin
                m_vl[ch] = 1'b0;
                m_st[ch] = 1'b0;
                last_w   = 0;
            end
        endcase
        e.ch = ch; e.width = last_w; e.st = m_st; e.vl = m_vl; e.due = due;
        sb.push_back(e);
    endtask

    task automatic wait_active(input int ch);
        for (int i = 0; i < 600; i++) begin
            if (act_o === 2'(ch)) break;
            @(negedge clk);
        end
        check("wait_active", act_o, ch);
    endtask

    task automatic pulse(input int ch, input int h);
        wait_active(ch);
        repeat (5) @(negedge clk);
        pwm[ch] = 1'b1;
        repeat (h) @(negedge clk);
        pwm[ch] = 1'b0;
        push_exp(ch, h, 0, cyc + 5);
        wait_active((ch + 1) % N);
    endtask

    task automatic overrange(input int ch, input int h);
        wait_active(ch);
        repeat (5) @(negedge clk);
        push_exp(ch, MAXV, 1, 0);
        pwm[ch] = 1'b1;
        repeat (h) @(negedge clk);
        pwm[ch] = 1'b0;
        wait_active((ch + 1) % N);
    endtask

    task automatic skip(input int ch);
        push_exp(ch, 0, 2, 0);
        wait_active((ch + 1) % N);
    endtask

    task automatic drain();
        for (int i = 0; i < 600 && sb.size() != 0; i++) @(negedge clk);
        check("drain", sb.size(), 0);
    endtask

    logic prev_strobe = 1'b0;
    always @(negedge clk) begin
        exp_t e;
        if (rst_n) begin
            if (strobe_o) begin
                check("strobe_single", prev_strobe, 0);
                if (sb.size() == 0) begin
                    check("unexpected_strobe", sb.size(), 1);
                end else begin
                    e = sb.pop_front();
                    check("next_channel", act_o, (e.ch + 1) % N);
                    check("pulse_width", pw_o, e.width);
                    check("state_vec", st_o, e.st);
                    check("valid_vec", vl_o, e.vl);
                    if (e.due != 0) check("latency", cyc, e.due);
                end
            end
            prev_strobe <= strobe_o;
        end
    end

    initial begin
        @(negedge clk);
        repeat (3) begin
            pwm = ~pwm;
            @(negedge clk);
        end
        check("rst_state", st_o, 0);
        check("rst_valid", vl_o, 0);
        check("rst_active", act_o, 0);
        check("rst_width", pw_o, 0);
        check("rst_strobe", strobe_o, 0);
        check("rst_fsm", dut.state_q, ST_IDLE);
        pwm = '0;
        en  = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("release_fsm", dut.state_q, ST_SYNC_LOW);

        pulse(0, 17);
        pulse(1, 8);

        pulse(2, 17);
        overrange(3, 30);
        skip(0);
        skip(1);
        pulse(2, 12);
        skip(3); skip(0); skip(1);
        pulse(2, 15);
        skip(3); skip(0); skip(1);
        pulse(2, 9);

        pulse(3, 17);
        pulse(0, 17);
        pulse(1, 17);
        pulse(2, 17);
        pulse(3, 17);
        drain();
        check("wrap_active", act_o, 0);

        skip(0);
        skip(1);
        wait_active(2);
        repeat (5) @(negedge clk);
        pwm[2] = 1'b1;
        repeat (6) @(negedge clk);
        en = 1'b0;
        repeat (4) @(negedge clk);
        pwm[2] = 1'b0;
        repeat (4) @(negedge clk);
        check("abort_fsm", dut.state_q, ST_IDLE);
        check("abort_active", act_o, 2);
        check("abort_width", pw_o, last_w);
        check("abort_state", st_o, m_st);
        check("abort_valid", vl_o, m_vl);
        check("abort_no_pending", sb.size(), 0);
        en = 1'b1;
        pulse(2, 17);
        drain();
        check("final_active", act_o, 3);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
